// File: rtl/pc_word_rr_merge_if.sv
// -----------------------------------------------------------------------------
// pc_word_rr_merge_if
// Bundle of the N-input PC word channel and the single merged output channel
// used by pc_word_rr_merge.
//   in_code    : NIn packed codes, input i at [i*NPCcode +: NPCcode]
//   in_payload : NIn packed payloads, same packing
//   in_v/in_a  : per-input valid / ack
//   out_code, out_payload, out_route : merged word and its source index
//   out_v/out_a: output valid / ack
// Modports: master = producers/consumer side (testbench), slave = merge block.
// -----------------------------------------------------------------------------
interface pc_word_rr_merge_if #(
    parameter int NIn      = 4,
    parameter int NPCcode  = 7,
    parameter int NPCdata  = 20,
    parameter int NPCroute = 5
);
    logic [NIn*NPCcode-1:0] in_code;
    logic [NIn*NPCdata-1:0] in_payload;
    logic [NIn-1:0]         in_v;
    logic [NIn-1:0]         in_a;
    logic [NPCcode-1:0]     out_code;
    logic [NPCdata-1:0]     out_payload;
    logic [NPCroute-1:0]    out_route;
    logic                   out_v;
    logic                   out_a;

    modport master (
        output in_code, in_payload, in_v, out_a,
        input  in_a, out_code, out_payload, out_route, out_v
    );

    modport slave (
        input  in_code, in_payload, in_v, out_a,
        output in_a, out_code, out_payload, out_route, out_v
    );
endinterface

// File: rtl/pc_word_rr_merge.sv
// -----------------------------------------------------------------------------
// pc_word_rr_merge
// Round-robin merge of NIn PC word inputs onto one PC word channel, with a
// 2-entry output FIFO so one word per cycle is sustained and output
// backpressure is decoupled from arbitration.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; empties the FIFO, input 0 gets first
//           priority, in_a forced low while asserted
//   bus   : pc_word_rr_merge_if.slave (inputs in_*, output out_*)
// Optional feature macro: PC_MERGE_BURST_EN -- the last granted input keeps
// priority for up to NBurst consecutive grants while it stays valid.
// -----------------------------------------------------------------------------
module pc_word_rr_merge #(
    parameter int NIn      = 4,
    parameter int NPCcode  = 7,
    parameter int NPCdata  = 20,
    parameter int NPCroute = 5,
    parameter int NBurst   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_word_rr_merge_if.slave    bus
);
    localparam int PW = $clog2(NIn);

    generate
        if ((2 ** NPCroute) < NIn) begin : g_route_chk
            $error("pc_word_rr_merge: NPCroute too narrow for NIn");
        end
    endgenerate

    // FIFO storage and pointers
    logic [NPCcode-1:0]  r_code    [2];
    logic [NPCdata-1:0]  r_payload [2];
    logic [NPCroute-1:0] r_route   [2];
    logic                r_rd;
    logic                r_wr;
    logic [1:0]          r_count;
    logic [PW-1:0]       r_ptr;

    logic                w_pop;
    logic                w_space;
    logic                w_found;
    logic                w_push;
    logic [PW-1:0]       w_gidx;
    logic [PW-1:0]       w_cand;
    logic [NIn-1:0]      w_in_a;
    logic [NPCcode-1:0]  w_code;
    logic [NPCdata-1:0]  w_payload;

`ifdef PC_MERGE_BURST_EN
    localparam int BW = $clog2(NBurst + 1);
    // consecutive grants given to r_ptr; zero means no burst in progress
    logic [BW-1:0]       r_burst_cnt;
    logic                w_burst_hold;
    assign w_burst_hold = (r_burst_cnt != '0) && (r_burst_cnt < BW'(NBurst))
                          && bus.in_v[r_ptr];
`endif

    // A full FIFO still has space when its head leaves this cycle.
    assign w_pop   = (r_count != 2'd0) && bus.out_a;
    assign w_space = (r_count != 2'd2) || bus.out_a;

    // Arbiter: first valid input searching upward from r_ptr+1, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_ptr;
        w_cand  = r_ptr;
`ifdef PC_MERGE_BURST_EN
        if (w_burst_hold) begin
            w_found = 1'b1;
            w_gidx  = r_ptr;
        end else begin
            w_found = 1'b0;
        end
`endif
        for (int k = 1; k <= NIn; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % NIn);
            if (!w_found && bus.in_v[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_push    = w_found && w_space && !reset;
    assign w_code    = bus.in_code[w_gidx*NPCcode +: NPCcode];
    assign w_payload = bus.in_payload[w_gidx*NPCdata +: NPCdata];

    // One-hot ack to the granted input only
    always_comb begin
        w_in_a = '0;
        if (w_push) begin
            w_in_a[w_gidx] = 1'b1;
        end else begin
            w_in_a = '0;
        end
    end

    assign bus.in_a        = w_in_a;
    assign bus.out_code    = r_code[r_rd];
    assign bus.out_payload = r_payload[r_rd];
    assign bus.out_route   = r_route[r_rd];
    assign bus.out_v       = (r_count != 2'd0);

    // FIFO write/read and round-robin pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < 2; e++) begin
                r_code[e]    <= '0;
                r_payload[e] <= '0;
                r_route[e]   <= '0;
            end
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= 2'd0;
            r_ptr   <= PW'(NIn - 1);
        end else begin
            if (w_push) begin
                r_code[r_wr]    <= w_code;
                r_payload[r_wr] <= w_payload;
                r_route[r_wr]   <= NPCroute'(w_gidx);
                r_wr            <= ~r_wr;
                r_ptr           <= w_gidx;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PC_MERGE_BURST_EN
    // Burst length tracking: extend while the same input keeps winning
    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (w_push) begin
            if ((w_gidx == r_ptr) && w_burst_hold) begin
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end else begin
                r_burst_cnt <= BW'(1);
            end
        end
    end
`endif
endmodule
